// File: rtl/fptd_ctrl_pkg.sv
// Shared types and constants for the turbo-decoder iteration controller.
package fptd_ctrl_pkg;

    // Width of the bit-error counter outputs.
    localparam int ERR_W = 7;

    // Default frame length in bits (also the error counter's clear value).
    localparam int FL_DEFAULT = 104;

    // Iteration sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SAMPLE = 3'd3,
        EVAL   = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/stall_detector.sv
// Counts consecutive iterations whose error count did not change and flags
// a stall when that run reaches STABLE_N. The flag reflects the count that
// the current evaluate strobe is about to store.
module stall_detector
    import fptd_ctrl_pkg::*;
#(
    parameter int STABLE_N = 2
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [ERR_W-1:0] error_count,
    input  logic [ERR_W-1:0] error_count_buff,
    input  logic             clear,
    input  logic             eval,
    output logic             stall
);

    localparam logic [2:0] STABLE_LIM = 3'(STABLE_N);

    logic [2:0] stable_cnt_r;
    logic [2:0] stable_next_s;

    // Next run length: saturating increment on an unchanged count, else restart.
    always_comb begin
        stable_next_s = 3'd0;
        stall         = 1'b0;
        if (error_count == error_count_buff) begin
            if (stable_cnt_r >= STABLE_LIM) begin
                stable_next_s = STABLE_LIM;
            end else begin
                stable_next_s = stable_cnt_r + 3'd1;
            end
        end else begin
            stable_next_s = 3'd0;
        end
        if (eval && (stable_next_s >= STABLE_LIM)) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Run-length register: cleared at frame start, updated once per evaluation.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stable_cnt_r <= 3'd0;
        end else if (clear) begin
            stable_cnt_r <= 3'd0;
        end else if (eval) begin
            stable_cnt_r <= stable_next_s;
        end else begin
            stable_cnt_r <= stable_cnt_r;
        end
    end

endmodule

// File: rtl/iteration_controller.sv
// Turbo-decoder iteration sequencer: clears the error counter, runs the
// decoder one iteration at a time, samples the error count after each
// iteration and stops on convergence, stall or iteration budget.
module iteration_controller
    import fptd_ctrl_pkg::*;
#(
    parameter int FL       = FL_DEFAULT,
    parameter int MAX_ITER = 32,
    parameter int STABLE_N = 2,
    parameter int IW       = 6
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic             Iter_Done,
    input  logic [ERR_W-1:0] Error_Count,
    input  logic [ERR_W-1:0] Error_Count_buff,
    input  logic             Ack,
    output logic             Busy,
    output logic             Dec_Run,
    output logic             Cnt_Enable,
    output logic             Cnt_nClear,
    output logic             Done,
    output logic             Converged,
    output logic [IW-1:0]    Iter_Count,
    output logic [ERR_W-1:0] Final_Errors
);

    // Reject parameter sets the datapath cannot represent.
    if (FL < 1 || FL >= (1 << ERR_W)) begin : g_bad_fl
        $error("iteration_controller: FL does not fit the error counter width");
    end
    if (MAX_ITER < 1 || MAX_ITER > 63 || MAX_ITER >= (1 << IW)) begin : g_bad_max_iter
        $error("iteration_controller: MAX_ITER out of range for IW");
    end
    if (STABLE_N < 1 || STABLE_N > 7) begin : g_bad_stable_n
        $error("iteration_controller: STABLE_N out of range");
    end

    localparam logic [IW-1:0] MAX_ITER_V = IW'(MAX_ITER);
    localparam logic [IW-1:0] ITER_ONE   = {{(IW-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [IW-1:0]    iter_count_r;
    logic [ERR_W-1:0] final_errors_r;
    logic             converged_r;
    logic             zero_s;
    logic             budget_s;
    logic             stall_s;
    logic             terminate_s;

    assign zero_s      = (Error_Count == {ERR_W{1'b0}});
    assign budget_s    = (iter_count_r == MAX_ITER_V);
    // Priority only matters for Converged; any of the three ends the frame.
    assign terminate_s = zero_s || stall_s || budget_s;

    // The first comparison is against the cleared value FL, so a stall at
    // iteration 1 is only possible if every bit of the frame is in error.
    stall_detector #(
        .STABLE_N (STABLE_N)
    ) u_stall (
        .Clock            (Clock),
        .nReset           (nReset),
        .error_count      (Error_Count),
        .error_count_buff (Error_Count_buff),
        .clear            (state_r == CLEAR),
        .eval             (state_r == EVAL),
        .stall            (stall_s)
    );

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; Start, Iter_Done and Ack only matter in their own state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (Start)       state_next_s = CLEAR;  else state_next_s = IDLE;
            CLEAR:   state_next_s = RUN;
            RUN:     if (Iter_Done)   state_next_s = SAMPLE; else state_next_s = RUN;
            SAMPLE:  state_next_s = EVAL;
            EVAL:    if (terminate_s) state_next_s = DONE;   else state_next_s = RUN;
            DONE:    if (Ack)         state_next_s = IDLE;   else state_next_s = DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // Moore strobes decoded from the state register.
    always_comb begin
        Busy       = 1'b1;
        Dec_Run    = 1'b0;
        Cnt_Enable = 1'b0;
        Cnt_nClear = 1'b1;
        Done       = 1'b0;
        case (state_r)
            IDLE:    Busy       = 1'b0;
            CLEAR:   Cnt_nClear = 1'b0;
            RUN:     Dec_Run    = 1'b1;
            SAMPLE:  Cnt_Enable = 1'b1;
            EVAL:    Busy       = 1'b1;
            DONE:    Done       = 1'b1;
            default: Busy       = 1'b0;
        endcase
    end

    // Result registers: cleared at frame start, counted in SAMPLE, latched on termination.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            iter_count_r   <= {IW{1'b0}};
            final_errors_r <= {ERR_W{1'b0}};
            converged_r    <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    iter_count_r <= {IW{1'b0}};
                    converged_r  <= 1'b0;
                end
                SAMPLE: begin
                    if (iter_count_r != MAX_ITER_V) begin
                        iter_count_r <= iter_count_r + ITER_ONE;
                    end
                end
                EVAL: begin
                    if (terminate_s) begin
                        final_errors_r <= Error_Count;
                        converged_r    <= zero_s;
                    end
                end
                default: begin
                    iter_count_r <= iter_count_r;
                end
            endcase
        end
    end

    assign Iter_Count   = iter_count_r;
    assign Final_Errors = final_errors_r;
    assign Converged    = converged_r;

endmodule

// File: tb/tb_iteration_controller.sv
// Directed bench for iteration_controller: a per-cycle vector table for a
// converging frame and handshake, plus hand sequences for stall, budget,
// priority and mid-frame reset.
module tb_iteration_controller;

    localparam int IW = 6;

    localparam logic [2:0] P_I = 3'd0;
    localparam logic [2:0] P_C = 3'd1;
    localparam logic [2:0] P_R = 3'd2;
    localparam logic [2:0] P_S = 3'd3;
    localparam logic [2:0] P_E = 3'd4;
    localparam logic [2:0] P_D = 3'd5;

    logic          Clock;
    logic          nReset;
    logic          Start;
    logic          Iter_Done;
    logic [6:0]    Error_Count;
    logic [6:0]    Error_Count_buff;
    logic          Ack;
    logic          Busy;
    logic          Dec_Run;
    logic          Cnt_Enable;
    logic          Cnt_nClear;
    logic          Done;
    logic          Converged;
    logic [IW-1:0] Iter_Count;
    logic [6:0]    Final_Errors;

    int checks   = 0;
    int failures = 0;

    iteration_controller #(
        .FL       (104),
        .MAX_ITER (4),
        .STABLE_N (2),
        .IW       (IW)
    ) dut (
        .Clock            (Clock),
        .nReset           (nReset),
        .Start            (Start),
        .Iter_Done        (Iter_Done),
        .Error_Count      (Error_Count),
        .Error_Count_buff (Error_Count_buff),
        .Ack              (Ack),
        .Busy             (Busy),
        .Dec_Run          (Dec_Run),
        .Cnt_Enable       (Cnt_Enable),
        .Cnt_nClear       (Cnt_nClear),
        .Done             (Done),
        .Converged        (Converged),
        .Iter_Count       (Iter_Count),
        .Final_Errors     (Final_Errors)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       s;
        logic       d;
        logic       a;
        logic [6:0] ec;
        logic [6:0] eb;
        logic [2:0] ph;
        int         iter;
        logic       conv;
        logic [6:0] ferr;
    } vec_t;

    vec_t vecs [16];

    // Expected {Busy, Dec_Run, Cnt_Enable, Cnt_nClear, Done} per state.
    function automatic logic [4:0] strobes(input logic [2:0] ph);
        case (ph)
            P_I:     return 5'b00010;
            P_C:     return 5'b10000;
            P_R:     return 5'b11010;
            P_S:     return 5'b10110;
            P_E:     return 5'b10010;
            P_D:     return 5'b10011;
            default: return 5'b00000;
        endcase
    endfunction

    // Drive one cycle of inputs on the falling edge, then settle after the rising edge.
    task automatic step(input logic s, input logic d, input logic a,
                        input logic [6:0] ec, input logic [6:0] eb);
        @(negedge Clock);
        Start = s; Iter_Done = d; Ack = a;
        Error_Count = ec; Error_Count_buff = eb;
        @(posedge Clock);
        #1;
    endtask

    // Compare strobes, optionally Iter_Count (iter >= 0) and results (full).
    task automatic check(input string nm, input logic [2:0] ph, input int iter,
                         input logic full, input logic conv, input logic [6:0] ferr);
        logic [4:0] exp_st;
        logic [4:0] act_st;
        exp_st = strobes(ph);
        act_st = {Busy, Dec_Run, Cnt_Enable, Cnt_nClear, Done};
        checks++;
        if (act_st !== exp_st) begin
            failures++;
            $display("FAIL %s strobes got=%b want=%b", nm, act_st, exp_st);
        end
        if (iter >= 0) begin
            checks++;
            if (Iter_Count !== 6'(iter)) begin
                failures++;
                $display("FAIL %s iter_count got=%0d want=%0d", nm, Iter_Count, iter);
            end
        end
        if (full) begin
            checks++;
            if (Converged !== conv) begin
                failures++;
                $display("FAIL %s converged got=%b want=%b", nm, Converged, conv);
            end
            checks++;
            if (Final_Errors !== ferr) begin
                failures++;
                $display("FAIL %s final_errors got=%0d want=%0d", nm, Final_Errors, ferr);
            end
        end
    endtask

    task automatic start_frame(input string nm);
        step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
        check({nm, "_clear"}, P_C, -1, 1'b0, 1'b0, 7'd0);
        step(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check({nm, "_run0"}, P_R, 0, 1'b0, 1'b0, 7'd0);
        checks++;
        if (Converged !== 1'b0) begin
            failures++;
            $display("FAIL %s_conv_cleared got=%b want=0", nm, Converged);
        end
    endtask

    // One decoder iteration n with the counts seen after its SAMPLE edge.
    task automatic do_iter(input string nm, input logic [6:0] ec, input logic [6:0] eb,
                           input int n, input logic [2:0] ph_end,
                           input logic conv, input logic [6:0] ferr);
        step(1'b0, 1'b1, 1'b0, ec, eb);
        check({nm, "_sample"}, P_S, n - 1, 1'b0, 1'b0, 7'd0);
        step(1'b0, 1'b0, 1'b0, ec, eb);
        check({nm, "_eval"}, P_E, n, 1'b0, 1'b0, 7'd0);
        step(1'b0, 1'b0, 1'b0, ec, eb);
        check({nm, "_end"}, ph_end, n, ph_end == P_D, conv, ferr);
    endtask

    task automatic ack_frame(input string nm, input int n, input logic conv, input logic [6:0] ferr);
        step(1'b0, 1'b0, 1'b1, 7'd0, 7'd0);
        check({nm, "_ack"}, P_I, n, 1'b1, conv, ferr);
    endtask

    initial begin
        nReset = 1'b0; Start = 1'b0; Iter_Done = 1'b0; Ack = 1'b0;
        Error_Count = 7'd0; Error_Count_buff = 7'd0;

        // Convergence at iteration 3, then DONE-state ignores and Ack.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 7'd0,  7'd0,   P_C, 0, 1'b0, 7'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 7'd0,  7'd0,   P_R, 0, 1'b0, 7'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 7'd0,  7'd0,   P_R, 0, 1'b0, 7'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 7'd40, 7'd104, P_S, 0, 1'b0, 7'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 7'd40, 7'd104, P_E, 1, 1'b0, 7'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 7'd40, 7'd104, P_R, 1, 1'b0, 7'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 7'd12, 7'd40,  P_S, 1, 1'b0, 7'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 7'd12, 7'd40,  P_E, 2, 1'b0, 7'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 7'd12, 7'd40,  P_R, 2, 1'b0, 7'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 7'd0,  7'd12,  P_S, 2, 1'b0, 7'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 7'd0,  7'd12,  P_E, 3, 1'b0, 7'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 7'd0,  7'd12,  P_D, 3, 1'b1, 7'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 7'd0,  7'd12,  P_D, 3, 1'b1, 7'd0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 7'd0,  7'd12,  P_D, 3, 1'b1, 7'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 7'd0,  7'd12,  P_I, 3, 1'b1, 7'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 7'd0,  7'd12,  P_I, 3, 1'b1, 7'd0};

        repeat (2) @(posedge Clock);
        #1;
        check("reset_held", P_I, 0, 1'b1, 1'b0, 7'd0);
        @(negedge Clock);
        nReset = 1'b1;
        @(posedge Clock);
        #1;
        check("reset_idle", P_I, 0, 1'b1, 1'b0, 7'd0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].s, vecs[i].d, vecs[i].a, vecs[i].ec, vecs[i].eb);
            check($sformatf("conv3_v%0d", i), vecs[i].ph, vecs[i].iter, 1'b1, vecs[i].conv, vecs[i].ferr);
        end

        // Stall at iteration 4: 20/104, 5/20, 5/5, 5/5.
        start_frame("stall4");
        do_iter("stall4_i1", 7'd20, 7'd104, 1, P_R, 1'b0, 7'd0);
        do_iter("stall4_i2", 7'd5,  7'd20,  2, P_R, 1'b0, 7'd0);
        do_iter("stall4_i3", 7'd5,  7'd5,   3, P_R, 1'b0, 7'd0);
        do_iter("stall4_i4", 7'd5,  7'd5,   4, P_D, 1'b0, 7'd5);
        ack_frame("stall4", 4, 1'b0, 7'd5);

        // Stall at iteration 3, before the budget runs out.
        start_frame("stall3");
        do_iter("stall3_i1", 7'd9, 7'd104, 1, P_R, 1'b0, 7'd0);
        do_iter("stall3_i2", 7'd9, 7'd9,   2, P_R, 1'b0, 7'd0);
        do_iter("stall3_i3", 7'd9, 7'd9,   3, P_D, 1'b0, 7'd9);
        ack_frame("stall3", 3, 1'b0, 7'd9);

        // Budget exhausted at MAX_ITER=4.
        start_frame("budget");
        do_iter("budget_i1", 7'd60, 7'd104, 1, P_R, 1'b0, 7'd0);
        do_iter("budget_i2", 7'd50, 7'd60,  2, P_R, 1'b0, 7'd0);
        do_iter("budget_i3", 7'd40, 7'd50,  3, P_R, 1'b0, 7'd0);
        do_iter("budget_i4", 7'd30, 7'd40,  4, P_D, 1'b0, 7'd30);
        ack_frame("budget", 4, 1'b0, 7'd30);

        // Zero errors on the last budgeted iteration: convergence wins.
        start_frame("prio_conv");
        do_iter("prio_conv_i1", 7'd8, 7'd104, 1, P_R, 1'b0, 7'd0);
        do_iter("prio_conv_i2", 7'd5, 7'd8,   2, P_R, 1'b0, 7'd0);
        do_iter("prio_conv_i3", 7'd3, 7'd5,   3, P_R, 1'b0, 7'd0);
        do_iter("prio_conv_i4", 7'd0, 7'd3,   4, P_D, 1'b1, 7'd0);
        ack_frame("prio_conv", 4, 1'b1, 7'd0);

        // Equal counts on the last budgeted iteration: not converged.
        start_frame("prio_stall");
        do_iter("prio_stall_i1", 7'd9, 7'd104, 1, P_R, 1'b0, 7'd0);
        do_iter("prio_stall_i2", 7'd7, 7'd9,   2, P_R, 1'b0, 7'd0);
        do_iter("prio_stall_i3", 7'd7, 7'd7,   3, P_R, 1'b0, 7'd0);
        do_iter("prio_stall_i4", 7'd7, 7'd7,   4, P_D, 1'b0, 7'd7);

        // Ack together with Start leaves the block idle, no new frame.
        step(1'b1, 1'b0, 1'b1, 7'd7, 7'd7);
        check("ack_start", P_I, 4, 1'b1, 1'b0, 7'd7);
        step(1'b0, 1'b0, 1'b0, 7'd7, 7'd7);
        check("ack_start_idle1", P_I, 4, 1'b1, 1'b0, 7'd7);
        step(1'b0, 1'b0, 1'b0, 7'd7, 7'd7);
        check("ack_start_idle2", P_I, 4, 1'b1, 1'b0, 7'd7);

        // Reset asserted during EVAL.
        start_frame("rst");
        step(1'b0, 1'b1, 1'b0, 7'd33, 7'd104);
        check("rst_sample", P_S, 0, 1'b0, 1'b0, 7'd0);
        step(1'b0, 1'b0, 1'b0, 7'd33, 7'd104);
        check("rst_eval", P_E, 1, 1'b0, 1'b0, 7'd0);
        @(negedge Clock);
        nReset = 1'b0;
        #1;
        check("rst_async", P_I, 0, 1'b1, 1'b0, 7'd0);
        #2;
        nReset = 1'b1;
        @(posedge Clock);
        #1;
        check("rst_after", P_I, 0, 1'b1, 1'b0, 7'd0);
        start_frame("rst_restart");
        do_iter("rst_restart_i1", 7'd33, 7'd104, 1, P_R, 1'b0, 7'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout reached before end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
